// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared keypad definitions: phase encodings, key-code field layout, matrix size.
// The vending machine scanner uses the same layout.
package keypad_matrix_emulator_pkg;

    localparam int KP_DIM      = 4;
    localparam int KEY_COL_MSB = 3;
    localparam int KEY_COL_LSB = 2;
    localparam int KEY_ROW_MSB = 1;
    localparam int KEY_ROW_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_GAP        = 3'd4
    } kp_state_t;

    // Field order matches key_code: [3:2] column, [1:0] row.
    typedef struct packed {
        logic [KEY_COL_MSB-KEY_COL_LSB:0] col;
        logic [KEY_ROW_MSB-KEY_ROW_LSB:0] row;
    } key_code_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_timer.sv
// Loadable saturating down-counter timing one contact phase; done when it reaches zero.
module keypad_phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad responder: takes a key code, then drives active-low rows
// against the scanner's column strobes through press bounce, hold, release bounce, gap.
import keypad_matrix_emulator_pkg::*;

module keypad_matrix_emulator #(
    parameter int HOLD_CYCLES   = 64,
    parameter int BOUNCE_CYCLES = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KP_DIM-1:0] col,
    input  logic [3:0]        key_code,
    input  logic              key_valid,
    output logic              key_ready,
    output logic [KP_DIM-1:0] row,
    output logic              busy,
    output logic              contact
);

    localparam int MAXC = max3(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    // Each phase of N cycles loads N-1 so the last cycle of the phase sees done.
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BOUNCE_LD = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

    kp_state_t     state, state_n;
    key_code_t     code_q;
    logic          contact_n;
    logic          ld;
    logic [CW-1:0] ld_val;
    logic          done;

    keypad_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            contact <= 1'b0;
            code_q  <= '0;
        end else begin
            state   <= state_n;
            contact <= contact_n;
            if (state == ST_IDLE && key_valid)
                code_q <= key_code_t'(key_code);
        end
    end

    always_comb begin
        state_n   = state;
        contact_n = contact;
        ld        = 1'b0;
        ld_val    = '0;
        case (state)
            ST_IDLE: begin
                contact_n = 1'b0;
                if (key_valid) begin
                    contact_n = 1'b1;
                    ld        = 1'b1;
                    if (BOUNCE_CYCLES > 0) begin
                        state_n = ST_BOUNCE_IN;
                        ld_val  = BOUNCE_LD;
                    end else begin
                        state_n = ST_HOLD;
                        ld_val  = HOLD_LD;
                    end
                end
            end
            ST_BOUNCE_IN: begin
                if (done) begin
                    state_n   = ST_HOLD;
                    contact_n = 1'b1;
                    ld        = 1'b1;
                    ld_val    = HOLD_LD;
                end else begin
                    contact_n = ~contact;
                end
            end
            ST_HOLD: begin
                contact_n = 1'b1;
                if (done) begin
                    contact_n = 1'b0;
                    ld        = 1'b1;
                    if (BOUNCE_CYCLES > 0) begin
                        state_n = ST_BOUNCE_OUT;
                        ld_val  = BOUNCE_LD;
                    end else begin
                        state_n = ST_GAP;
                        ld_val  = GAP_LD;
                    end
                end
            end
            ST_BOUNCE_OUT: begin
                if (done) begin
                    state_n   = ST_GAP;
                    contact_n = 1'b0;
                    ld        = 1'b1;
                    ld_val    = GAP_LD;
                end else begin
                    contact_n = ~contact;
                end
            end
            ST_GAP: begin
                contact_n = 1'b0;
                if (done)
                    state_n = ST_IDLE;
            end
            default: begin
                state_n   = ST_IDLE;
                contact_n = 1'b0;
            end
        endcase
    end

    assign key_ready = (state == ST_IDLE) & ~reset;
    assign busy      = (state != ST_IDLE) & ~reset;

    // Only the latched key's column strobe matters; other columns never pull a row.
    for (genvar r = 0; r < KP_DIM; r++) begin : g_row
        assign row[r] = ~(contact & (code_q.row == 2'(r)) & ~col[code_q.col]);
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench: default-timing instance (a) and short-timing instance (b, B=0 H=8 G=4).
module tb_keypad_matrix_emulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_a, col_b, code_a, code_b, row_a, row_b;
    logic       valid_a, valid_b, ready_a, ready_b, busy_a, busy_b, cont_a, cont_b;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    keypad_matrix_emulator u_a (
        .clk(clk), .reset(reset), .col(col_a), .key_code(code_a), .key_valid(valid_a),
        .key_ready(ready_a), .row(row_a), .busy(busy_a), .contact(cont_a)
    );

    keypad_matrix_emulator #(.HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .GAP_CYCLES(4)) u_b (
        .clk(clk), .reset(reset), .col(col_b), .key_code(code_b), .key_valid(valid_b),
        .key_ready(ready_b), .row(row_b), .busy(busy_b), .contact(cont_b)
    );

    // Expected contact of the default instance k cycles after the transfer edge.
    function automatic logic exp_cont_a(input int k);
        if (k <= 8)  return (k % 2) == 1;
        if (k <= 72) return 1'b1;
        if (k <= 80) return ((k - 73) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        reset = 1'b1; valid_a = 1'b1; code_a = 4'h3; col_a = 4'b1110;
        valid_b = 1'b1; code_b = 4'h0; col_b = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL rst_ready cyc%0d got %b want 0", i, ready_a); end
            n_cmp++; if (row_a !== 4'b1111) begin n_err++; $display("FAIL rst_row cyc%0d got %b want 1111", i, row_a); end
            n_cmp++; if (busy_a !== 1'b0 || cont_a !== 1'b0) begin n_err++; $display("FAIL rst_busy cyc%0d got %b%b want 00", i, busy_a, cont_a); end
            n_cmp++; if (busy_b !== 1'b0 || ready_b !== 1'b0) begin n_err++; $display("FAIL rst_b cyc%0d got %b%b want 00", i, busy_b, ready_b); end
        end
        reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0; #1;
        n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL post_rst_ready_a got %b want 1", ready_a); end
        n_cmp++; if (ready_b !== 1'b1) begin n_err++; $display("FAIL post_rst_ready_b got %b want 1", ready_b); end
        @(posedge clk); #1;
        n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_err++; $display("FAIL no_xfer got %b%b want 00", busy_a, busy_b); end
    endtask

    task automatic test_col_rotate();
        logic [3:0] pat [4];
        logic [3:0] exp_row;
        logic       ec;
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
        code_b = 4'b0110; valid_b = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin valid_b = 1'b0; code_b = 4'hF; end
            col_b = pat[k % 4]; #1;
            ec = (k <= 8);
            exp_row = (ec && col_b == 4'b1101) ? 4'b1011 : 4'b1111;
            n_cmp++; if (row_b !== exp_row) begin n_err++; $display("FAIL rot_row k%0d col %b got %b want %b", k, col_b, row_b, exp_row); end
            n_cmp++; if (cont_b !== ec) begin n_err++; $display("FAIL rot_contact k%0d got %b want %b", k, cont_b, ec); end
            n_cmp++; if (busy_b !== (k <= 12)) begin n_err++; $display("FAIL rot_busy k%0d got %b want %b", k, busy_b, (k <= 12)); end
            n_cmp++; if (ready_b !== (k >= 13)) begin n_err++; $display("FAIL rot_ready k%0d got %b want %b", k, ready_b, (k >= 13)); end
        end
    endtask

    task automatic test_bounce_default();
        logic       ec;
        logic [3:0] exp_row;
        code_a = 4'hF; col_a = 4'b0111; valid_a = 1'b1;
        for (int k = 1; k <= 98; k++) begin
            @(posedge clk); #1;
            if (k == 1) valid_a = 1'b0;
            ec = (k <= 96) ? exp_cont_a(k) : 1'b0;
            exp_row = ec ? 4'b0111 : 4'b1111;
            n_cmp++; if (cont_a !== ec) begin n_err++; $display("FAIL bnc_contact k%0d got %b want %b", k, cont_a, ec); end
            n_cmp++; if (row_a !== exp_row) begin n_err++; $display("FAIL bnc_row k%0d got %b want %b", k, row_a, exp_row); end
            n_cmp++; if (busy_a !== (k <= 96)) begin n_err++; $display("FAIL bnc_busy k%0d got %b want %b", k, busy_a, (k <= 96)); end
            n_cmp++; if (ready_a !== (k >= 97)) begin n_err++; $display("FAIL bnc_ready k%0d got %b want %b", k, ready_a, (k >= 97)); end
        end
    endtask

    task automatic test_back_to_back();
        logic       ec;
        logic [3:0] exp_row;
        code_b = 4'h0; col_b = 4'b1110; valid_b = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            if (k == 1)  code_b = 4'h5;
            if (k == 14) begin valid_b = 1'b0; code_b = 4'hA; end
            col_b = (k <= 13) ? 4'b1110 : 4'b1101; #1;
            ec = (k <= 8) || (k >= 14 && k <= 21);
            exp_row = !ec ? 4'b1111 : (k <= 13) ? 4'b1110 : 4'b1101;
            n_cmp++; if (cont_b !== ec) begin n_err++; $display("FAIL b2b_contact k%0d got %b want %b", k, cont_b, ec); end
            n_cmp++; if (row_b !== exp_row) begin n_err++; $display("FAIL b2b_row k%0d got %b want %b", k, row_b, exp_row); end
            n_cmp++; if (ready_b !== (k == 13 || k >= 26)) begin n_err++; $display("FAIL b2b_ready k%0d got %b want %b", k, ready_b, (k == 13 || k >= 26)); end
            n_cmp++; if (busy_b !== !(k == 13 || k >= 26)) begin n_err++; $display("FAIL b2b_busy k%0d got %b want %b", k, busy_b, !(k == 13 || k >= 26)); end
        end
    endtask

    task automatic test_multi_col_and_reset();
        code_a = 4'h9; col_a = 4'b1111; valid_a = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) valid_a = 1'b0;
        end
        col_a = 4'b0000; #1;
        n_cmp++; if (row_a !== 4'b1101) begin n_err++; $display("FAIL allcol_row got %b want 1101", row_a); end
        col_a = 4'b1111; #1;
        n_cmp++; if (row_a !== 4'b1111) begin n_err++; $display("FAIL nocol_row got %b want 1111", row_a); end
        col_a = 4'b1011; #1;
        n_cmp++; if (row_a !== 4'b1101) begin n_err++; $display("FAIL col2_row got %b want 1101", row_a); end
        col_a = 4'b0100; #1;
        n_cmp++; if (row_a !== 4'b1111) begin n_err++; $display("FAIL othercols_row got %b want 1111", row_a); end
        col_a = 4'b1011;
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cont_a !== 1'b0 || row_a !== 4'b1111) begin n_err++; $display("FAIL midrst got %b/%b want 0/1111", cont_a, row_a); end
        n_cmp++; if (busy_a !== 1'b0 || ready_a !== 1'b0) begin n_err++; $display("FAIL midrst_hs got %b%b want 00", busy_a, ready_a); end
        reset = 1'b0; #1;
        n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", ready_a); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (cont_a !== 1'b0 || busy_a !== 1'b0 || row_a !== 4'b1111) begin
                n_err++; $display("FAIL postrst_idle k%0d got %b%b/%b want 00/1111", k, cont_a, busy_a, row_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_col_rotate();
        test_bounce_default();
        test_back_to_back();
        test_multi_col_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
